data_bus_responder: RTL and testbench
=====================================

# data_bus_responder

Responder end of the core's data-memory bus: accepts the MEM-stage `ce`/`we`/`sel`/`addr`/`data` request and serves it from an on-chip word-addressed data RAM or a memory-mapped timer. RAM and timer reads are combinational so the MEM stage gets read data in the same cycle. All writes and timer state update on the clock edge. The timer drives `timer_int_o` back to the core.

## Interface
- `RAM_AW`, 10, log2 of RAM depth in 32-bit words (default 1024 words = 4 KiB)
- `TIMER_HI`, 4'h1, value of `addr_i[31:28]` that selects the timer window
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  one clock; reset is synchronous and active-high
- `ce_i`  in  1  request valid this cycle
- `we_i`  in  1  1 = write, 0 = read
- `addr_i`  in  32  byte address; bits [1:0] ignored
- `sel_i`  in  4  byte-lane enables; bit k covers `data_i[8k+7:8k]`
- `data_i`  in  32  write data
- `data_o`  out  32  read data, combinational
- `timer_int_o`  out  1  timer interrupt request, level, registered source

## Operation
- Decode:
  - `addr_i[31:28]==TIMER_HI` selects the timer, register offset `addr_i[3:2]`.
  - Any other address selects the RAM at word index `addr_i[RAM_AW+1:2]`. Upper bits are ignored, so the RAM aliases modulo its depth.
- RAM write: on an edge with `ce_i=1`, `we_i=1`, `rst=0`, write each lane whose `sel_i` bit is 1. Other lanes are unchanged. `sel_i=0` is a legal no-op.
- RAM read: when `ce_i=1` and `we_i=0`, `data_o` is the full stored word regardless of `sel_i`. The core extracts bytes and halfwords itself.
- `data_o = 0` when `rst=1`, `ce_i=0`, or `we_i=1`. A read in the same cycle as a write is not possible on this bus.
- RAM contents are not reset.
- Timer registers (reset value in brackets):
  - 0x0 COUNT [0]: read/write.
  - 0x4 COMPARE [32'hFFFF_FFFF]: read/write.
  - 0x8 CTRL [0]: bit0 EN, bit1 IE; other bits read 0.
  - 0xC STATUS [0]: bit0 PEND; write 1 to clear, write 0 has no effect.
- Timer writes take effect only when `sel_i=4'b1111`. Partial-lane writes to the timer are ignored. Timer reads return the register value with unused bits 0.
- Count rule per edge, using pre-edge register values:
  - If a COUNT write is present, COUNT takes the written value. Software write beats hardware.
  - Else if EN and COUNT==COMPARE: COUNT goes to 0 and PEND is set.
  - Else if EN: COUNT increments by 1, 32-bit wrap.
- PEND: a hardware set and a W1C clear on the same edge resolve to PEND=1.
- A CTRL write changes EN for the following edges only. The edge that writes EN=1 does not increment.
- `timer_int_o = PEND & IE`, from registers only, with no combinational path from bus inputs.

## Timing
- Read latency 0 cycles (combinational). Write latency 1 edge.
- Timer period with EN=1 is COMPARE+1 cycles. With COMPARE=N, PEND rises N+1 edges after the edge that set EN, provided COUNT was 0.
- `timer_int_o` changes only after a clock edge, at most 1 edge after PEND or IE changes.
- Reset:
  - An edge with `rst=1` loads all timer reset values and suppresses all writes.
  - `data_o` and `timer_int_o` are 0 while `rst=1` and after the reset edge.
  - Reset mid-count discards PEND and COUNT.

## Test plan
- **RAM byte-lane write:**
  - Stimulus: write 32'h11223344 at 0x0000_0010 with sel 1111, then write 32'hAABBCCDD at the same address with sel 0101.
  - Required response: a read returns 32'h11BB33DD.
- **Alias and idle:**
  - Stimulus: write 32'hDEADBEEF at 0x0000_0004; read 0x0000_1004 (with `RAM_AW`=10); then drop `ce_i`.
  - Required response: the read returns 32'hDEADBEEF; `data_o` is 0 once `ce_i`=0.
- **Timer period:**
  - Stimulus: write COMPARE=3, then write CTRL=3.
  - Required response: COUNT reads 1,2,3,0 on the next four cycles; `timer_int_o` rises after the 4th edge and repeats every 4 cycles.
- **W1C vs set collision:**
  - Stimulus: with PEND=1, write STATUS=1 on the same edge as a COUNT==COMPARE match.
  - Required response: PEND stays 1. A W1C on a non-match edge clears it, and `timer_int_o` is 0 on the next cycle.
- **Write priority and partial lanes:**
  - Stimulus: write COUNT=5 on a match edge; separately write COMPARE with sel 0011.
  - Required response: COUNT reads 5 and PEND is not set; COMPARE is unchanged.
- **Reset mid-operation:**
  - Stimulus: assert `rst` for one edge while the timer is running and PEND=1.
  - Required response: COUNT=0, COMPARE=FFFF_FFFF, CTRL=0, `timer_int_o`=0; a RAM write presented during `rst` leaves the word unchanged.

Source files
------------

// File: rtl/data_bus_responder_if.sv
// Data-memory bus between the core MEM stage (master) and the responder (slave).
interface data_bus_responder_if;
  logic        ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (output ce_i, we_i, addr_i, sel_i, data_i, input  data_o);
  modport slave  (input  ce_i, we_i, addr_i, sel_i, data_i, output data_o);
endinterface

// File: rtl/data_bus_responder.sv
// Data bus responder: byte-lane word RAM plus a memory-mapped compare timer.
// Reads are combinational; writes and timer state update on the rising edge.
module dbr_ram_lane #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  assign rdata = mem[addr];
endmodule

module data_bus_responder #(
  parameter int          RAM_AW   = 10,
  parameter logic [3:0]  TIMER_HI = 4'h1
) (
  input  logic                  clk,
  input  logic                  rst,
  data_bus_responder_if.slave   bus,
  output logic                  timer_int_o
);
  localparam int NUM_LANES = 4;

  logic                         tmr_sel, rd_en, wr_en, ram_wr, tmr_wr;
  logic [1:0]                   reg_off;
  logic [RAM_AW-1:0]            word_idx;
  logic [NUM_LANES-1:0][7:0]    ram_rd;
  logic [NUM_LANES-1:0][7:0]    ram_wd;
  logic [31:0]                  count, compare, tmr_rd;
  logic                         en, ie, pend, match, cnt_wr, hw_set;
  logic                         unused_addr;

  assign tmr_sel  = (bus.addr_i[31:28] == TIMER_HI);
  assign rd_en    = bus.ce_i & ~bus.we_i & ~rst;
  assign wr_en    = bus.ce_i &  bus.we_i & ~rst;
  assign ram_wr   = wr_en & ~tmr_sel;
  // Timer registers only accept full-word stores.
  assign tmr_wr   = wr_en & tmr_sel & (bus.sel_i == 4'hF);
  assign reg_off  = bus.addr_i[3:2];
  assign word_idx = bus.addr_i[RAM_AW+1:2];
  assign ram_wd   = bus.data_i;
  assign unused_addr = &{1'b0, bus.addr_i[27:RAM_AW+2], bus.addr_i[1:0]};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    dbr_ram_lane #(.AW(RAM_AW)) u_lane (
      .clk   (clk),
      .we    (ram_wr & bus.sel_i[g]),
      .addr  (word_idx),
      .wdata (ram_wd[g]),
      .rdata (ram_rd[g])
    );
  end

  assign match  = en && (count == compare);
  assign cnt_wr = tmr_wr && (reg_off == 2'd0);
  // A software COUNT write pre-empts the wrap, so no PEND set on that edge.
  assign hw_set = match && !cnt_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      compare <= 32'hFFFF_FFFF;
      en      <= 1'b0;
      ie      <= 1'b0;
      pend    <= 1'b0;
    end else begin
      if (cnt_wr)     count <= bus.data_i;
      else if (match) count <= '0;
      else if (en)    count <= count + 32'd1;

      if (tmr_wr && reg_off == 2'd1) compare <= bus.data_i;

      if (tmr_wr && reg_off == 2'd2) begin
        en <= bus.data_i[0];
        ie <= bus.data_i[1];
      end

      if (hw_set)                                          pend <= 1'b1;
      else if (tmr_wr && reg_off == 2'd3 && bus.data_i[0]) pend <= 1'b0;
    end
  end

  always_comb begin
    tmr_rd = '0;
    case (reg_off)
      2'd0: tmr_rd = count;
      2'd1: tmr_rd = compare;
      2'd2: tmr_rd = {30'd0, ie, en};
      2'd3: tmr_rd = {31'd0, pend};
      default: tmr_rd = '0;
    endcase
  end

  always_comb begin
    bus.data_o = '0;
    if (rd_en) bus.data_o = tmr_sel ? tmr_rd : ram_rd;
  end

  assign timer_int_o = pend & ie & ~rst;
endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder: RAM lanes/alias, timer period, W1C, priority, reset.
module tb_data_bus_responder;
  localparam logic [31:0] T_COUNT = 32'h1000_0000;
  localparam logic [31:0] T_CMP   = 32'h1000_0004;
  localparam logic [31:0] T_CTRL  = 32'h1000_0008;
  localparam logic [31:0] T_STAT  = 32'h1000_000C;

  logic clk = 1'b0;
  logic rst;
  logic timer_int;

  data_bus_responder_if bus();

  data_bus_responder #(.RAM_AW(10), .TIMER_HI(4'h1)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .timer_int_o (timer_int)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
    bus.ce_i   = 1'b1;
    bus.we_i   = 1'b1;
    bus.addr_i = addr;
    bus.data_i = data;
    bus.sel_i  = sel;
    @(posedge clk);
    #1;
    bus.ce_i = 1'b0;
    bus.we_i = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
    bus.ce_i   = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = addr;
    bus.sel_i  = 4'b0001;
    #2;
    e = sb.pop_front();
    chk(e.tag, bus.data_o, e.exp);
    bus.ce_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] seq [4];
    seq[0] = 32'd1; seq[1] = 32'd2; seq[2] = 32'd3; seq[3] = 32'd0;

    rst = 1'b1;
    bus.ce_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.sel_i = '0; bus.data_i = '0;
    tick; tick;
    rd(T_CMP, 32'h0, "rd_during_rst");
    chk("int_during_rst0", {31'd0, timer_int}, 32'd0);
    rst = 1'b0;
    tick;
    rd(T_CMP,   32'hFFFF_FFFF, "cmp_reset");
    rd(T_COUNT, 32'h0,         "count_reset");
    rd(T_CTRL,  32'h0,         "ctrl_reset");

    // RAM byte lanes
    wr(32'h0000_0010, 32'h1122_3344, 4'b1111);
    wr(32'h0000_0010, 32'hAABB_CCDD, 4'b0101);
    rd(32'h0000_0010, 32'h11BB_33DD, "ram_lanes");

    // Alias, idle, sel=0 no-op
    wr(32'h0000_0004, 32'hDEAD_BEEF, 4'b1111);
    rd(32'h0000_1004, 32'hDEAD_BEEF, "ram_alias");
    #1;
    chk("idle_zero", bus.data_o, 32'h0);
    tick;
    wr(32'h0000_0004, 32'h0, 4'b0000);
    rd(32'h0000_0004, 32'hDEAD_BEEF, "sel0_noop");

    // Timer period: COMPARE=3, then EN|IE
    wr(T_CMP,  32'd3, 4'b1111);
    wr(T_CTRL, 32'd3, 4'b1111);
    rd(T_CTRL, 32'd3, "ctrl_rd");
    for (int i = 0; i < 4; i++) begin
      tick;
      rd(T_COUNT, seq[i], $sformatf("period_count%0d", i));
      chk($sformatf("period_int%0d", i), {31'd0, timer_int}, (i == 3) ? 32'd1 : 32'd0);
    end
    tick;
    rd(T_COUNT, 32'd1, "count_after_wrap");
    tick; tick;
    rd(T_COUNT, 32'd3, "count_pre_match");

    // W1C on a match edge: set wins
    wr(T_STAT, 32'd1, 4'b1111);
    rd(T_STAT,  32'd1, "pend_collision");
    rd(T_COUNT, 32'd0, "count_collision");
    chk("int_collision", {31'd0, timer_int}, 32'd1);
    // W1C on a non-match edge clears
    wr(T_STAT, 32'd1, 4'b1111);
    rd(T_STAT, 32'd0, "pend_cleared");
    chk("int_cleared", {31'd0, timer_int}, 32'd0);

    // COUNT write beats match on the same edge
    tick; tick;
    wr(T_COUNT, 32'd5, 4'b1111);
    rd(T_COUNT, 32'd5, "count_sw_wins");
    rd(T_STAT,  32'd0, "pend_not_set");
    // Partial-lane COMPARE write ignored
    wr(T_CMP, 32'd7, 4'b0011);
    rd(T_CMP, 32'd3, "cmp_partial");

    // Reset while running with PEND=1
    wr(T_COUNT, 32'd2, 4'b1111);
    tick; tick;
    chk("int_before_rst", {31'd0, timer_int}, 32'd1);
    rst = 1'b1;
    bus.ce_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h0000_0010;
    bus.data_i = 32'hFFFF_FFFF; bus.sel_i = 4'b1111;
    #1;
    chk("int_rst_high", {31'd0, timer_int}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; bus.ce_i = 1'b0; bus.we_i = 1'b0;
    rd(T_COUNT, 32'h0,         "rst_count");
    rd(T_CMP,   32'hFFFF_FFFF, "rst_cmp");
    rd(T_CTRL,  32'h0,         "rst_ctrl");
    tick;
    rd(T_STAT,  32'h0,         "rst_pend");
    chk("rst_int", {31'd0, timer_int}, 32'd0);
    rd(32'h0000_0010, 32'h11BB_33DD, "ram_wr_in_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
